// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: circular FIFO of instr/PC pairs
// feeding a registered output stage that ID consumes one entry per cycle.
module instr_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Push_IN,
    input  logic [31:0]       Instr_IN,
    input  logic [31:0]       Instr_PC_IN,
    output logic              Full_OUT,
    output logic              Empty_OUT,
    output logic [ADDR_W:0]   Count_OUT,
    input  logic              Request_Instr1,
    input  logic              Freeze_IN,
    input  logic              Flush_IN,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [31:0]       Instr1_PC_Plus4_OUT,
    output logic              Instr1_Valid_OUT
);

    logic [63:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       instr1_q, instr1_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              full, empty;
    logic              push_acc, pop;
    logic [63:0]       head;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign Full_OUT  = full;
    assign Empty_OUT = empty;
    assign Count_OUT = count_q;

    // Full is judged before any same-cycle pop, so a push at Full is always dropped.
    assign push_acc = Push_IN && !full && !Flush_IN;
    assign pop      = Request_Instr1 && !Freeze_IN && !Flush_IN && !empty;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr1_d = instr1_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;

        if (Flush_IN) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            instr1_d = '0;
            pc_d     = '0;
            pc4_d    = '0;
            valid_d  = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop);

            if (!Freeze_IN) begin
                if (pop) begin
                    instr1_d = head[63:32];
                    pc_d     = head[31:0];
                    pc4_d    = head[31:0] + 32'd4;
                    valid_d  = 1'b1;
                end else begin
                    instr1_d = '0;
                    pc_d     = '0;
                    pc4_d    = '0;
                    valid_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            instr1_q <= '0;
            pc_q     <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr1_q <= instr1_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    // Storage is deliberately left out of reset; count/pointers guard its use.
    always_ff @(posedge CLK) begin
        if (push_acc) mem_q[wr_ptr_q] <= {Instr_IN, Instr_PC_IN};
    end

    assign Instr1_OUT          = instr1_q;
    assign Instr1_PC_OUT       = pc_q;
    assign Instr1_PC_Plus4_OUT = pc4_q;
    assign Instr1_Valid_OUT    = valid_q;

endmodule
